// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - pipeline EX stage: ALU, address/branch-target generation, iterative mult/div owning HI/LO
module execute_stage #(
   parameter int DATA_SIZE    = 32,
   parameter int ADDRESS_SIZE = 32,
   parameter int MD_ITER      = 32
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [DATA_SIZE-1:0]    ID_EX_A,
   input  logic [DATA_SIZE-1:0]    ID_EX_B,
   input  logic [15:0]             ID_EX_imm,
   input  logic [ADDRESS_SIZE-1:0] ID_EX_PC,
   input  logic [5:0]              ID_EX_op,
   input  logic [5:0]              ID_EX_funct,
   input  logic [4:0]              ID_EX_dest,
   input  logic [1:0]              ID_EX_instruc_type,
   input  logic                    ID_EX_valid,
   input  logic                    mem_stall_c,
   output logic [DATA_SIZE-1:0]    EX_MEM_result,
   output logic [DATA_SIZE-1:0]    EX_MEM_B,
   output logic [4:0]              EX_MEM_dest,
   output logic [5:0]              EX_MEM_op,
   output logic [1:0]              EX_MEM_instruc_type,
   output logic [ADDRESS_SIZE-1:0] EX_MEM_targetPC,
   output logic                    EX_MEM_valid,
   output logic                    branch_taken,
   output logic                    ex_stall_c
);
   localparam int CW = $clog2(MD_ITER + 1);
   localparam int D  = DATA_SIZE;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]              state;
   logic [CW-1:0]           count;
   logic                    md_is_div;
   logic [D-1:0]            md_opnd;
   logic [2*D-1:0]          acc;
   logic [D-1:0]            hi;
   logic [D-1:0]            lo;

   logic                    is_rtype, is_mult, is_div, md_start;
   logic [D-1:0]            sext_imm, alu_result;
   logic [ADDRESS_SIZE-1:0] target_pc;
   logic [D:0]              mult_sum;
   logic [D:0]              div_shift;
   logic [D+1:0]            div_trial;
   logic [2*D-1:0]          md_next;

   assign is_rtype  = (ID_EX_op == 6'h00);
   assign is_mult   = is_rtype && (ID_EX_funct == 6'h18);
   assign is_div    = is_rtype && (ID_EX_funct == 6'h1A);
   assign md_start  = (state == ST_IDLE) && ID_EX_valid && (is_mult || is_div);
   assign ex_stall_c = mem_stall_c || md_start || (state == ST_BUSY);

   assign sext_imm  = {{(D-16){ID_EX_imm[15]}}, ID_EX_imm};
   assign target_pc = ID_EX_PC + ADDRESS_SIZE'(4)
                    + {{(ADDRESS_SIZE-18){ID_EX_imm[15]}}, ID_EX_imm, 2'b00};

   always_comb begin
      alu_result = '0;
      if (is_rtype) begin
         case (ID_EX_funct)
            6'h20: alu_result = ID_EX_A + ID_EX_B;
            6'h22: alu_result = ID_EX_A - ID_EX_B;
            6'h24: alu_result = ID_EX_A & ID_EX_B;
            6'h25: alu_result = ID_EX_A | ID_EX_B;
            6'h2A: alu_result = ($signed(ID_EX_A) < $signed(ID_EX_B)) ? D'(1) : '0;
            6'h10: alu_result = hi;
            6'h12: alu_result = lo;
            default: alu_result = '0;
         endcase
      end else begin
         case (ID_EX_op)
            6'h08, 6'h23, 6'h2B: alu_result = ID_EX_A + sext_imm;
            default:             alu_result = '0;
         endcase
      end
   end

   // acc holds {partial product, remaining multiplier} for mult and {remainder, quotient} for div
   assign mult_sum  = {1'b0, acc[2*D-1:D]} + (acc[0] ? {1'b0, md_opnd} : '0);
   assign div_shift = acc[2*D-1:D-1];
   assign div_trial = {1'b0, div_shift} - {2'b00, md_opnd};

   always_comb begin
      md_next = {mult_sum, acc[D-1:1]};
      if (md_is_div) begin
         if (div_trial[D+1])
            md_next = {acc[2*D-2:0], 1'b0};
         else
            md_next = {div_trial[D-1:0], acc[D-2:0], 1'b1};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state               <= ST_IDLE;
         count               <= '0;
         md_is_div           <= 1'b0;
         md_opnd             <= '0;
         acc                 <= '0;
         hi                  <= '0;
         lo                  <= '0;
         EX_MEM_result       <= '0;
         EX_MEM_B            <= '0;
         EX_MEM_dest         <= '0;
         EX_MEM_op           <= '0;
         EX_MEM_instruc_type <= '0;
         EX_MEM_targetPC     <= '0;
         EX_MEM_valid        <= 1'b0;
         branch_taken        <= 1'b0;
      end else if (!mem_stall_c) begin
         case (state)
            ST_IDLE: begin
               if (md_start) begin
                  md_is_div <= is_div;
                  md_opnd   <= is_div ? ID_EX_B : ID_EX_A;
                  if (is_div && (ID_EX_B == '0)) begin
                     acc   <= {ID_EX_A, {D{1'b1}}};
                     count <= '0;
                     state <= ST_DONE;
                  end else begin
                     acc   <= {{D{1'b0}}, (is_div ? ID_EX_A : ID_EX_B)};
                     count <= CW'(MD_ITER);
                     state <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               acc   <= md_next;
               count <= count - CW'(1);
               if (count == CW'(1))
                  state <= ST_DONE;
            end
            ST_DONE: begin
               hi    <= acc[2*D-1:D];
               lo    <= acc[D-1:0];
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         if (md_start || (state == ST_BUSY)) begin
            EX_MEM_valid        <= 1'b0;
            EX_MEM_instruc_type <= 2'b00;
            branch_taken        <= 1'b0;
         end else begin
            EX_MEM_result       <= (state == ST_DONE) ? '0 : alu_result;
            EX_MEM_B            <= ID_EX_B;
            EX_MEM_dest         <= ID_EX_dest;
            EX_MEM_op           <= ID_EX_op;
            EX_MEM_targetPC     <= target_pc;
            EX_MEM_valid        <= ID_EX_valid;
            EX_MEM_instruc_type <= (ID_EX_valid && (state != ST_DONE)) ? ID_EX_instruc_type : 2'b00;
            branch_taken        <= ID_EX_valid && (ID_EX_op == 6'h04) && (ID_EX_A == ID_EX_B);
         end
      end
   end
endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - table-driven and sequence checks for execute_stage
module tb_execute_stage;
   logic        clock, reset_n;
   logic [31:0] id_a, id_b, id_pc;
   logic [15:0] id_imm;
   logic [5:0]  id_op, id_funct;
   logic [4:0]  id_dest;
   logic [1:0]  id_type;
   logic        id_valid, mem_stall_c;
   logic [31:0] ex_result, ex_b, ex_tpc;
   logic [4:0]  ex_dest;
   logic [5:0]  ex_op;
   logic [1:0]  ex_type;
   logic        ex_valid, branch_taken, ex_stall_c;

   int n_vec = 0;
   int n_fail = 0;

   execute_stage #(.DATA_SIZE(32), .ADDRESS_SIZE(32), .MD_ITER(32)) dut (
      .clock(clock), .reset_n(reset_n),
      .ID_EX_A(id_a), .ID_EX_B(id_b), .ID_EX_imm(id_imm), .ID_EX_PC(id_pc),
      .ID_EX_op(id_op), .ID_EX_funct(id_funct), .ID_EX_dest(id_dest),
      .ID_EX_instruc_type(id_type), .ID_EX_valid(id_valid), .mem_stall_c(mem_stall_c),
      .EX_MEM_result(ex_result), .EX_MEM_B(ex_b), .EX_MEM_dest(ex_dest), .EX_MEM_op(ex_op),
      .EX_MEM_instruc_type(ex_type), .EX_MEM_targetPC(ex_tpc), .EX_MEM_valid(ex_valid),
      .branch_taken(branch_taken), .ex_stall_c(ex_stall_c)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [5:0]  op, funct;
      logic [31:0] a, b;
      logic [15:0] imm;
      logic [31:0] pc;
      logic [4:0]  dest;
      logic [1:0]  typ;
      logic        vld;
      logic [31:0] e_res;
      logic        e_vld;
      logic [1:0]  e_typ;
      logic        e_tkn;
      logic [31:0] e_tpc;
      logic        chk_res, chk_tpc;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(logic [5:0] op, logic [5:0] funct, logic [31:0] a, logic [31:0] b,
                               logic [15:0] imm, logic [31:0] pc, logic [4:0] dest, logic [1:0] typ,
                               logic vld, logic [31:0] e_res, logic e_vld, logic [1:0] e_typ,
                               logic e_tkn, logic [31:0] e_tpc, logic chk_res, logic chk_tpc);
      vec_t v;
      v.op = op; v.funct = funct; v.a = a; v.b = b; v.imm = imm; v.pc = pc;
      v.dest = dest; v.typ = typ; v.vld = vld; v.e_res = e_res; v.e_vld = e_vld;
      v.e_typ = e_typ; v.e_tkn = e_tkn; v.e_tpc = e_tpc; v.chk_res = chk_res; v.chk_tpc = chk_tpc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] funct, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] imm, input logic [31:0] pc,
                        input logic [4:0] dest, input logic [1:0] typ, input logic vld);
      id_op = op; id_funct = funct; id_a = a; id_b = b; id_imm = imm; id_pc = pc;
      id_dest = dest; id_type = typ; id_valid = vld;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic read_hilo(input string nm, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      drive(6'h00, 6'h10, 32'h0, 32'h0, 16'h0, 32'h0, 5'd4, 2'b10, 1'b1);
      tick();
      chk({nm, ".mfhi"}, ex_result, exp_hi);
      drive(6'h00, 6'h12, 32'h0, 32'h0, 16'h0, 32'h0, 5'd5, 2'b10, 1'b1);
      tick();
      chk({nm, ".mflo"}, ex_result, exp_lo);
   endtask

   // Counts ex_stall_c cycles for one mult/div, optionally injecting a memory stall window
   task automatic md_run(input string nm, input logic [5:0] funct, input logic [31:0] a,
                         input logic [31:0] b, input int st, input int len, input int exp_stalls);
      int stalls = 0;
      int k = 0;
      drive(6'h00, funct, a, b, 16'h0, 32'h0, 5'd0, 2'b00, 1'b1);
      while (k < 200) begin
         mem_stall_c = (k >= st) && (k < st + len);
         #1;
         if (!ex_stall_c) break;
         stalls++;
         tick();
         chk($sformatf("%s.bubble%0d", nm, k), {31'b0, ex_valid}, 32'd0);
         k++;
      end
      mem_stall_c = 1'b0;
      chk({nm, ".stall_cycles"}, stalls, exp_stalls);
      tick();
      chk({nm, ".retire_valid"}, {31'b0, ex_valid}, 32'd1);
      chk({nm, ".retire_type"}, {30'b0, ex_type}, 32'd0);
      chk({nm, ".retire_result"}, ex_result, 32'd0);
   endtask

   initial begin
      tbl[0]  = mk(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 32'h0, 5'd3, 2'b10, 1, 32'd12, 1, 2'b10, 0, 0, 1, 0);
      tbl[1]  = mk(6'h00, 6'h22, 32'd3, 32'd5, 16'h0, 32'h0, 5'd4, 2'b10, 1, 32'hFFFF_FFFE, 1, 2'b10, 0, 0, 1, 0);
      tbl[2]  = mk(6'h00, 6'h24, 32'hF0F0, 32'hFF00, 16'h0, 32'h0, 5'd5, 2'b10, 1, 32'hF000, 1, 2'b10, 0, 0, 1, 0);
      tbl[3]  = mk(6'h00, 6'h25, 32'hF0F0, 32'h0F00, 16'h0, 32'h0, 5'd6, 2'b10, 1, 32'hFFF0, 1, 2'b10, 0, 0, 1, 0);
      tbl[4]  = mk(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1, 16'h0, 32'h0, 5'd7, 2'b10, 1, 32'd1, 1, 2'b10, 0, 0, 1, 0);
      tbl[5]  = mk(6'h00, 6'h2A, 32'd1, 32'hFFFF_FFFF, 16'h0, 32'h0, 5'd7, 2'b10, 1, 32'd0, 1, 2'b10, 0, 0, 1, 0);
      tbl[6]  = mk(6'h08, 6'h20, 32'd16, 32'd0, 16'hFFFF, 32'h0, 5'd8, 2'b10, 1, 32'd15, 1, 2'b10, 0, 0, 1, 0);
      tbl[7]  = mk(6'h08, 6'h00, 32'hFFFF_FFFF, 32'd0, 16'h0001, 32'h0, 5'd8, 2'b10, 1, 32'd0, 1, 2'b10, 0, 0, 1, 0);
      tbl[8]  = mk(6'h23, 6'h00, 32'h100, 32'd0, 16'hFFFC, 32'h0, 5'd9, 2'b10, 1, 32'hFC, 1, 2'b10, 0, 0, 1, 0);
      tbl[9]  = mk(6'h2B, 6'h00, 32'h40, 32'hDEAD, 16'h0008, 32'h0, 5'd0, 2'b00, 1, 32'h48, 1, 2'b00, 0, 0, 1, 0);
      tbl[10] = mk(6'h04, 6'h00, 32'd9, 32'd9, 16'hFFFE, 32'h20, 5'd0, 2'b00, 1, 32'd0, 1, 2'b00, 1, 32'h1C, 1, 1);
      tbl[11] = mk(6'h04, 6'h00, 32'd9, 32'd8, 16'hFFFE, 32'h20, 5'd0, 2'b00, 1, 32'd0, 1, 2'b00, 0, 32'h1C, 1, 1);
      tbl[12] = mk(6'h3F, 6'h20, 32'd5, 32'd6, 16'h0, 32'h0, 5'd7, 2'b10, 1, 32'd0, 1, 2'b10, 0, 0, 1, 0);
      tbl[13] = mk(6'h00, 6'h20, 32'd1, 32'd1, 16'h0, 32'h0, 5'd2, 2'b10, 0, 32'd0, 0, 2'b00, 0, 0, 0, 0);
      tbl[14] = mk(6'h04, 6'h00, 32'd3, 32'd3, 16'h0, 32'h0, 5'd0, 2'b00, 0, 32'd0, 0, 2'b00, 0, 0, 0, 0);
      tbl[15] = mk(6'h04, 6'h00, 32'd4, 32'd4, 16'h0003, 32'h100, 5'd0, 2'b00, 1, 32'd0, 1, 2'b00, 1, 32'h110, 1, 1);

      reset_n = 1'b0;
      mem_stall_c = 1'b0;
      drive(6'h0, 6'h0, 32'h0, 32'h0, 16'h0, 32'h0, 5'd0, 2'b00, 1'b0);
      tick(); tick();
      reset_n = 1'b1;

      // Asynchronous reset taken mid-cycle
      drive(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 32'h0, 5'd3, 2'b10, 1'b1);
      tick();
      chk("pre_reset.result", ex_result, 32'd12);
      #2 reset_n = 1'b0;
      #1;
      chk("reset.result", ex_result, 32'd0);
      chk("reset.valid", {31'b0, ex_valid}, 32'd0);
      chk("reset.dest", {27'b0, ex_dest}, 32'd0);
      chk("reset.type", {30'b0, ex_type}, 32'd0);
      chk("reset.tpc", ex_tpc, 32'd0);
      chk("reset.taken", {31'b0, branch_taken}, 32'd0);
      tick();
      reset_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].op, tbl[i].funct, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].pc,
               tbl[i].dest, tbl[i].typ, tbl[i].vld);
         #1;
         chk($sformatf("v%0d.stall", i), {31'b0, ex_stall_c}, 32'd0);
         tick();
         if (tbl[i].chk_res) chk($sformatf("v%0d.result", i), ex_result, tbl[i].e_res);
         if (tbl[i].chk_tpc) chk($sformatf("v%0d.tpc", i), ex_tpc, tbl[i].e_tpc);
         chk($sformatf("v%0d.valid", i), {31'b0, ex_valid}, {31'b0, tbl[i].e_vld});
         chk($sformatf("v%0d.type", i), {30'b0, ex_type}, {30'b0, tbl[i].e_typ});
         chk($sformatf("v%0d.taken", i), {31'b0, branch_taken}, {31'b0, tbl[i].e_tkn});
         chk($sformatf("v%0d.dest", i), {27'b0, ex_dest}, {27'b0, tbl[i].dest});
         chk($sformatf("v%0d.op", i), {26'b0, ex_op}, {26'b0, tbl[i].op});
         chk($sformatf("v%0d.B", i), ex_b, tbl[i].b);
      end

      // Memory-stage stall freezes registered outputs
      drive(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 32'h0, 5'd3, 2'b10, 1'b1);
      tick();
      mem_stall_c = 1'b1;
      drive(6'h00, 6'h22, 32'd20, 32'd1, 16'h0, 32'h0, 5'd9, 2'b10, 1'b1);
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("hold%0d.stall", c), {31'b0, ex_stall_c}, 32'd1);
         tick();
         chk($sformatf("hold%0d.result", c), ex_result, 32'd12);
         chk($sformatf("hold%0d.dest", c), {27'b0, ex_dest}, 32'd3);
      end
      mem_stall_c = 1'b0;
      tick();
      chk("hold_release.result", ex_result, 32'd19);

      // Reset while BUSY aborts without touching HI/LO
      drive(6'h00, 6'h18, 32'd3, 32'd5, 16'h0, 32'h0, 5'd0, 2'b00, 1'b1);
      for (int c = 0; c < 10; c++) tick();
      #2 reset_n = 1'b0;
      drive(6'h0, 6'h0, 32'h0, 32'h0, 16'h0, 32'h0, 5'd0, 2'b00, 1'b0);
      #1;
      chk("busy_reset.stall", {31'b0, ex_stall_c}, 32'd0);
      tick();
      reset_n = 1'b1;
      read_hilo("busy_reset", 32'd0, 32'd0);

      md_run("mult", 6'h18, 32'hFFFF_FFFF, 32'd2, 999, 0, 33);
      read_hilo("mult", 32'd1, 32'hFFFF_FFFE);

      md_run("div", 6'h1A, 32'd100, 32'd7, 999, 0, 33);
      read_hilo("div", 32'd2, 32'd14);

      md_run("div0", 6'h1A, 32'd5, 32'd0, 999, 0, 1);
      read_hilo("div0", 32'd5, 32'hFFFF_FFFF);

      md_run("mult_memstall", 6'h18, 32'd3, 32'd5, 5, 3, 36);
      read_hilo("mult_memstall", 32'd0, 32'd15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline EX stage. Consumes ID/EX register contents and produces the EX_MEM_* bundle that the memory stage consumes directly.
- Computes ALU results, load/store effective addresses and branch targets.
- Hosts an iterative 32-cycle unsigned multiply/divide unit that owns the HI/LO registers.
- Stalls upstream while the multiply/divide unit is busy, or while the memory stage requests a stall.

Parameters:
- DATA_SIZE, 32, datapath width (matches `DATA_SIZE).
- ADDRESS_SIZE, 32, address/PC width (matches `ADDRESS_SIZE).
- MD_ITER, 32, multiply/divide iteration count.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- ID_EX_A  input  DATA_SIZE  rs operand.
- ID_EX_B  input  DATA_SIZE  rt operand (also the store data).
- ID_EX_imm  input  16  raw immediate.
- ID_EX_PC  input  ADDRESS_SIZE  PC of the instruction.
- ID_EX_op  input  6  opcode.
- ID_EX_funct  input  6  funct field for op 6'h00.
- ID_EX_dest  input  5  destination register.
- ID_EX_instruc_type  input  2  bit1 = writes a GPR.
- ID_EX_valid  input  1  instruction present.
- mem_stall_c  input  1  memory stage stall request.
- EX_MEM_result  output  DATA_SIZE  ALU result or effective address.
- EX_MEM_B  output  DATA_SIZE  store data.
- EX_MEM_dest  output  5  destination register.
- EX_MEM_op  output  6  opcode passthrough.
- EX_MEM_instruc_type  output  2  type passthrough (forced as specified below).
- EX_MEM_targetPC  output  ADDRESS_SIZE  branch target.
- EX_MEM_valid  output  1  bundle valid.
- branch_taken  output  1  registered; beq condition true.
- ex_stall_c  output  1  combinational; upstream must hold ID_EX_* when high.

Behaviour:
- Reset (reset_n low, asynchronous): all EX_MEM_* outputs = 0, branch_taken = 0, HI = LO = 0, FSM = IDLE, iteration counter = 0. Reset mid-iteration aborts the operation; HI/LO are not updated.
- Supported ops, R-type (op 6'h00), selected by funct:
  - add 20: A+B
  - sub 22: A−B
  - and 24: A&B
  - or 25: A|B
  - slt 2A: signed A<B → 1, else 0
  - mult 18
  - div 1A
  - mfhi 10: result = HI
  - mflo 12: result = LO
- Supported ops, I-type:
  - addi 08: A+sext(imm)
  - lw 23 / sw 2B: result = A+sext(imm)
  - beq 04: targetPC = PC+4+(sext(imm)<<2); branch_taken = (A==B)
- Unlisted op/funct: result = 0, passthrough of the other fields unchanged. All arithmetic wraps modulo 2^32; no overflow traps.
- Single-cycle ops: 1-cycle latency; registered on the posedge after the ID_EX_* inputs are presented. EX_MEM_B = ID_EX_B. Other fields pass through. EX_MEM_valid = ID_EX_valid.
- Register hold: when mem_stall_c = 1, every EX_MEM_* output, branch_taken and the FSM hold, and ex_stall_c = 1. mem_stall_c takes priority over every other event.
- Multiply/divide FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY: when a valid mult/div is presented. Operands are latched, counter = MD_ITER, and ex_stall_c is asserted that same cycle.
  - BUSY:
    - mult performs shift-add, one bit per cycle, into a 64-bit accumulator.
    - div performs restoring division, one quotient bit per cycle.
    - The counter decrements each cycle; at 0 → DONE.
  - DONE: HI/LO are written (mult: HI = product[63:32], LO = product[31:0]; div: LO = quotient, HI = remainder). ex_stall_c deasserts and the state returns to IDLE.
  - ex_stall_c = 1 for the accept cycle plus all of BUSY: MD_ITER+1 cycles total.
  - Output during the operation: EX_MEM_valid = 0 (bubble) on every edge while stalled. On the DONE edge the mult/div retires with EX_MEM_valid = 1, EX_MEM_instruc_type = 2'b00 (no GPR write) and EX_MEM_result = 0.
- Division by zero: detected at accept. The operation goes directly to DONE the next cycle with LO = 32'hFFFF_FFFF and HI = dividend; ex_stall_c is high for exactly 1 cycle.
- mfhi/mflo issued immediately after mult/div: upstream is held by the stall, so it always observes the updated HI/LO. HI/LO write-then-read in the same cycle is not possible.
- ID_EX_valid = 0: EX_MEM_valid = 0 and EX_MEM_instruc_type = 0. The FSM does not start. branch_taken = 0.

Test Plan:
- Reset with reset_n low asynchronously mid-cycle → all outputs 0 immediately. Release, then add A=5 B=7 dest=3 → next edge EX_MEM_result = 12, EX_MEM_dest = 3, EX_MEM_valid = 1.
- lw A=0x100 imm=0xFFFC → EX_MEM_result = 0xFC, EX_MEM_op = 0x23. sw A=0x40 imm=8 B=0xDEAD → result = 0x48, EX_MEM_B = 0xDEAD.
- beq PC=0x20 A=B=9 imm=0xFFFE → targetPC = 0x1C, branch_taken = 1. With A≠B → branch_taken = 0.
- mult A=0xFFFF_FFFF B=2 followed by mfhi, then mflo → ex_stall_c high 33 cycles. mfhi then returns 1 and mflo returns 0xFFFF_FFFE.
- div A=100 B=7 → LO = 14, HI = 2 after 33 stall cycles. div A=5 B=0 → 1 stall cycle, LO = 0xFFFF_FFFF, HI = 5.
- mem_stall_c held 3 cycles during a BUSY mult → outputs frozen and the counter paused. Completion is delayed by exactly 3 cycles. Reset asserted during BUSY → HI/LO remain at their prior values of 0.
